// File: rtl/sr_drive_ctrl_if.sv
// sr_drive_ctrl_if
// Request handshake between a requester and the SR latch drive controller.
//   req_valid : a request is present (requester -> controller)
//   req_level : target latch state, 1 = set, 0 = reset (requester -> controller)
//   req_ready : controller is idle and will accept on this edge (controller -> requester)
interface sr_drive_ctrl_if;
  logic req_valid;
  logic req_level;
  logic req_ready;

  modport master (output req_valid, output req_level, input req_ready);
  modport slave  (input req_valid, input req_level, output req_ready);
endinterface

// File: rtl/sr_drive_ctrl.sv
// sr_drive_ctrl
// Drives an external SR latch to a requested level and verifies it through the
// latch readback. Each attempt is a PULSE_W-cycle s or r pulse, SETTLE quiet
// cycles, then a one-cycle check of q_fb. A failed check is retried until
// MAX_TRY attempts have been made, after which the sticky err flag is raised.
// All outputs are registered.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_if     : request handshake (slave side: req_valid, req_level in, req_ready out)
//   q_fb       : latch q readback
//   s, r       : set / reset commands to the latch (never both high)
//   done       : one-cycle pulse when the latch is verified at the target level
//   err        : sticky failure flag
//   err_clr    : synchronous clear of err (a failure in the same cycle wins)
module sr_drive_ctrl #(
  parameter int PULSE_W = 2,
  parameter int SETTLE  = 1,
  parameter int MAX_TRY = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  sr_drive_ctrl_if.slave  req_if,
  input  logic            q_fb,
  output logic            s,
  output logic            r,
  output logic            done,
  output logic            err,
  input  logic            err_clr
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PULSE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_CHECK = 2'd3;

  localparam logic [3:0] PULSE_LAST  = 4'(PULSE_W - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [2:0] TRY_LAST    = 3'(MAX_TRY);

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] try_q, try_d;
  logic       level_q, level_d;
  logic       s_q, s_d;
  logic       r_q, r_d;
  logic       ready_q, ready_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  // Next-state and next-output logic. The s/r/ready/done values computed here
  // are the ones that will be visible in the state being entered, so every
  // output is a plain flop. s_d and r_d are only ever set as a complementary
  // pair from a single level, which keeps them mutually exclusive.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    try_d   = try_q;
    level_d = level_q;
    s_d     = 1'b0;
    r_d     = 1'b0;
    ready_d = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q & ~err_clr;

    case (state_q)
      ST_IDLE: begin
        // ready_q is low in the first cycle after reset, so nothing is
        // accepted until req_ready has actually been shown high.
        ready_d = 1'b1;
        if (req_if.req_valid && ready_q) begin
          level_d = req_if.req_level;
          try_d   = 3'd1;
          cnt_d   = 4'd0;
          state_d = ST_PULSE;
          s_d     = req_if.req_level;
          r_d     = ~req_if.req_level;
          ready_d = 1'b0;
        end
      end
      ST_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = 4'd0;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + 4'd1;
          s_d   = level_q;
          r_d   = ~level_q;
        end
      end
      ST_GAP: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = 4'd0;
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_CHECK: begin
        cnt_d = 4'd0;
        if (q_fb == level_q) begin
          done_d  = 1'b1;
          ready_d = 1'b1;
          try_d   = 3'd0;
          state_d = ST_IDLE;
        end else if (try_q < TRY_LAST) begin
          try_d   = try_q + 3'd1;
          s_d     = level_q;
          r_d     = ~level_q;
          state_d = ST_PULSE;
        end else begin
          err_d   = 1'b1;
          ready_d = 1'b1;
          try_d   = 3'd0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers. Reset clears everything asynchronously so the
  // latch drive drops immediately and any request in flight is abandoned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      try_q   <= 3'd0;
      level_q <= 1'b0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      try_q   <= try_d;
      level_q <= level_d;
      s_q     <= s_d;
      r_q     <= r_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign s                = s_q;
  assign r                = r_q;
  assign done             = done_q;
  assign err              = err_q;
  assign req_if.req_ready = ready_q;

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// tb_sr_drive_ctrl
// Self-checking bench for sr_drive_ctrl. A transaction-level reference model
// predicts s/r/done/err/req_ready from elapsed cycles since acceptance:
// every attempt lasts PULSE_W + SETTLE + 1 cycles, the last of which samples q_fb.
module tb_sr_drive_ctrl;

  localparam int PW  = 2;
  localparam int ST  = 1;
  localparam int MT  = 3;
  localparam int L   = PW + ST + 1;

  logic clk = 1'b0;
  logic rst_n;
  logic q_fb;
  logic s, r, done, err;
  logic err_clr;

  sr_drive_ctrl_if bus ();

  sr_drive_ctrl #(.PULSE_W(PW), .SETTLE(ST), .MAX_TRY(MT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_if  (bus),
    .q_fb    (q_fb),
    .s       (s),
    .r       (r),
    .done    (done),
    .err     (err),
    .err_clr (err_clr)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // q_fb source: 0 = ideal latch following s/r one cycle later, 1 = held, 2 = random
  int q_mode;

  // Reference model state
  logic m_busy, m_lvl, m_ready, m_done, m_err, m_s, m_r;
  int   m_t;

  // Forget any request in flight, as a reset does.
  task automatic model_reset();
    m_busy = 0; m_lvl = 0; m_ready = 0; m_done = 0;
    m_err = 0; m_s = 0; m_r = 0; m_t = 0;
  endtask

  // Predict the outputs of the next cycle from this cycle's inputs.
  task automatic model_step();
    int o, a;
    m_done = 0;
    m_err  = m_err & ~err_clr;
    if (!m_busy) begin
      if (bus.req_valid && m_ready) begin
        m_busy = 1;
        m_lvl  = bus.req_level;
        m_t    = 1;
      end
    end else begin
      o = (m_t - 1) % L;
      a = (m_t - 1) / L;
      if (o == L - 1) begin
        if (q_fb == m_lvl) begin
          m_done = 1;
          m_busy = 0;
        end else if (a + 1 < MT) begin
          m_t++;
        end else begin
          m_err  = 1;
          m_busy = 0;
        end
      end else begin
        m_t++;
      end
    end
    m_ready = !m_busy;
    m_s = m_busy && (((m_t - 1) % L) < PW) && m_lvl;
    m_r = m_busy && (((m_t - 1) % L) < PW) && !m_lvl;
  endtask

  // Advance one clock: update the model, let the environment latch respond,
  // and return at the following falling edge where outputs are sampled.
  task automatic tick();
    logic q_next;
    model_step();
    q_next = q_fb;
    if (s) q_next = 1'b1;
    else if (r) q_next = 1'b0;
    @(posedge clk);
    #1;
    if (q_mode == 0) q_fb = q_next;
    @(negedge clk);
  endtask

  // Outputs while reset is held, then req_ready on the first edge after release.
  task automatic test_reset();
    rst_n = 1'b0; bus.req_valid = 1'b0; bus.req_level = 1'b0;
    err_clr = 1'b0; q_fb = 1'b0; q_mode = 0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({s, r, done, err, bus.req_ready} !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL reset_hold: {s,r,done,err,ready}=%b expected 00000", {s, r, done, err, bus.req_ready});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release_ready: got %b expected 0", bus.req_ready);
    end
    @(negedge clk);
    tick();
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_first_edge_ready: got %b expected 1", bus.req_ready);
    end
  endtask

  // Set request with an ideal latch: s for PW cycles, done in cycle 1+PW+ST+1.
  task automatic test_set();
    int done_cyc = 0, s_cnt = 0;
    q_mode = 0; q_fb = 1'b0;
    for (int i = 1; i <= L + 2; i++) begin
      bus.req_valid = (i == 1); bus.req_level = 1'b1;
      tick();
      if (s) s_cnt++;
      if (done && done_cyc == 0) done_cyc = i;
      checks++;
      if ({s, r, done, err, bus.req_ready} !== {m_s, m_r, m_done, m_err, m_ready}) begin
        errors++;
        $display("[TB] FAIL set_cyc%0d: {s,r,done,err,ready}=%b expected %b", i,
                 {s, r, done, err, bus.req_ready}, {m_s, m_r, m_done, m_err, m_ready});
      end
    end
    checks++;
    if (done_cyc != 5) begin
      errors++;
      $display("[TB] FAIL set_latency: done in cycle %0d expected 5", done_cyc);
    end
    checks++;
    if (s_cnt != PW) begin
      errors++;
      $display("[TB] FAIL set_pulse_width: s high %0d cycles expected %0d", s_cnt, PW);
    end
  endtask

  // Reset request (level 0), optionally when the latch already reads 0.
  task automatic test_clear(input string tag);
    int done_cyc = 0, r_cnt = 0, s_cnt = 0;
    q_mode = 0;
    for (int i = 1; i <= L + 2; i++) begin
      bus.req_valid = (i == 1); bus.req_level = 1'b0;
      tick();
      if (r) r_cnt++;
      if (s) s_cnt++;
      if (done && done_cyc == 0) done_cyc = i;
      checks++;
      if ({s, r, done, err, bus.req_ready} !== {m_s, m_r, m_done, m_err, m_ready}) begin
        errors++;
        $display("[TB] FAIL %s_cyc%0d: {s,r,done,err,ready}=%b expected %b", tag, i,
                 {s, r, done, err, bus.req_ready}, {m_s, m_r, m_done, m_err, m_ready});
      end
    end
    checks++;
    if (r_cnt != PW || s_cnt != 0 || done_cyc != 5) begin
      errors++;
      $display("[TB] FAIL %s_shape: r=%0d s=%0d done_cyc=%0d expected r=%0d s=0 done_cyc=5",
               tag, r_cnt, s_cnt, done_cyc, PW);
    end
  endtask

  // Stuck latch: MT attempts, then err, no done, ready back high.
  task automatic test_stuck();
    int s_cnt = 0, d_cnt = 0;
    q_mode = 1; q_fb = 1'b0;
    for (int i = 1; i <= MT * L + 1; i++) begin
      bus.req_valid = (i == 1); bus.req_level = 1'b1;
      tick();
      if (s) s_cnt++;
      if (done) d_cnt++;
      checks++;
      if ({s, r, done, err, bus.req_ready} !== {m_s, m_r, m_done, m_err, m_ready}) begin
        errors++;
        $display("[TB] FAIL stuck_cyc%0d: {s,r,done,err,ready}=%b expected %b", i,
                 {s, r, done, err, bus.req_ready}, {m_s, m_r, m_done, m_err, m_ready});
      end
    end
    checks++;
    if (s_cnt != MT * PW || d_cnt != 0 || err !== 1'b1 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stuck_summary: s_cycles=%0d done=%0d err=%b ready=%b expected %0d 0 1 1",
               s_cnt, d_cnt, err, bus.req_ready, MT * PW);
    end
  endtask

  // err_clr coinciding with the final failed check leaves err set; a lone
  // err_clr pulse clears it. The request is accepted despite err=1.
  task automatic test_err_clr();
    q_mode = 1; q_fb = 1'b0;
    for (int i = 1; i <= MT * L + 1; i++) begin
      bus.req_valid = (i == 1); bus.req_level = 1'b1;
      err_clr = (m_busy && m_t == MT * L);
      tick();
      checks++;
      if ({s, r, done, err, bus.req_ready} !== {m_s, m_r, m_done, m_err, m_ready}) begin
        errors++;
        $display("[TB] FAIL errclr_cyc%0d: {s,r,done,err,ready}=%b expected %b", i,
                 {s, r, done, err, bus.req_ready}, {m_s, m_r, m_done, m_err, m_ready});
      end
    end
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL errclr_priority: err=%b expected 1", err);
    end
    bus.req_valid = 1'b0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL errclr_clear: err=%b expected 0", err);
    end
  endtask

  // req_valid held high: each new request is taken in the done cycle.
  task automatic test_back_to_back();
    int d_cnt = 0, md_cnt = 0;
    q_mode = 0;
    bus.req_valid = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      bus.req_level = 1'($urandom_range(0, 1));
      tick();
      if (done) d_cnt++;
      if (m_done) md_cnt++;
      checks++;
      if ({s, r, done, err, bus.req_ready} !== {m_s, m_r, m_done, m_err, m_ready}) begin
        errors++;
        $display("[TB] FAIL b2b_cyc%0d: {s,r,done,err,ready}=%b expected %b", i,
                 {s, r, done, err, bus.req_ready}, {m_s, m_r, m_done, m_err, m_ready});
      end
    end
    checks++;
    if (d_cnt != md_cnt || d_cnt < 40 / (L + 1)) begin
      errors++;
      $display("[TB] FAIL b2b_done_count: got %0d expected %0d", d_cnt, md_cnt);
    end
    bus.req_valid = 1'b0;
    for (int i = 0; i < L + 1; i++) tick();
  endtask

  // Reset mid-pulse drops s at once; a later request still completes.
  task automatic test_reset_mid_pulse();
    int done_cyc = 0;
    q_mode = 0; q_fb = 1'b0;
    bus.req_valid = 1'b1; bus.req_level = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    checks++;
    if (s !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rstpulse_pre: s=%b expected 1", s);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({s, r, done, err, bus.req_ready} !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL rstpulse_async: {s,r,done,err,ready}=%b expected 00000", {s, r, done, err, bus.req_ready});
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 1; i <= L + 2; i++) begin
      bus.req_valid = (i == 1); bus.req_level = 1'b1;
      tick();
      if (done && done_cyc == 0) done_cyc = i;
      checks++;
      if ({s, r, done, err, bus.req_ready} !== {m_s, m_r, m_done, m_err, m_ready}) begin
        errors++;
        $display("[TB] FAIL rstpulse_cyc%0d: {s,r,done,err,ready}=%b expected %b", i,
                 {s, r, done, err, bus.req_ready}, {m_s, m_r, m_done, m_err, m_ready});
      end
    end
    checks++;
    if (done_cyc != 5) begin
      errors++;
      $display("[TB] FAIL rstpulse_after: done in cycle %0d expected 5", done_cyc);
    end
  endtask

  // Random traffic: s/r exclusivity and full agreement with the model.
  task automatic test_random();
    q_mode = 2;
    for (int i = 0; i < 10000; i++) begin
      bus.req_valid = 1'($urandom_range(0, 1));
      bus.req_level = 1'($urandom_range(0, 1));
      q_fb          = 1'($urandom_range(0, 1));
      err_clr       = ($urandom_range(0, 15) == 0);
      tick();
      checks++;
      if ((s & r) !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rand_sr_excl_cyc%0d: s=%b r=%b expected not both 1", i, s, r);
      end
      checks++;
      if ({s, r, done, err, bus.req_ready} !== {m_s, m_r, m_done, m_err, m_ready}) begin
        errors++;
        $display("[TB] FAIL rand_cyc%0d: {s,r,done,err,ready}=%b expected %b", i,
                 {s, r, done, err, bus.req_ready}, {m_s, m_r, m_done, m_err, m_ready});
      end
    end
    err_clr = 1'b0;
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_set();
    test_clear("clear");
    test_clear("already_low");
    test_stuck();
    test_err_clr();
    test_back_to_back();
    test_reset_mid_pulse();
    test_random();
    $display("[TB] all scenarios complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
